parity_frame_rx: RTL

PARITY_FRAME_RX -- requirements
Module: parity_frame_rx

---
 rtl/parity_frame_rx_pkg.sv | 17 +
 rtl/parity_frame_rx_if.sv | 28 ++
 rtl/parity_frame_rx_sync_2ff.sv | 24 ++
 rtl/parity_frame_rx.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/parity_frame_rx_pkg.sv
// Shared types and parameter defaults for the parity framed serial receiver.
package parity_frame_rx_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned OVS_DEF    = 16;

  // Receiver FSM states, in frame order, with BREAK for a line held low.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/parity_frame_rx_if.sv
// Serial line input plus received word/status outputs of parity_frame_rx.
interface parity_frame_rx_if
  import parity_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) ();

  logic              tick;
  logic              rx;
  logic [DATA_W-1:0] data;
  logic              data_valid;
  logic              parity_err;
  logic              frame_err;
  logic              busy;

  // Line/strobe driver side.
  modport master (
    output tick, rx,
    input  data, data_valid, parity_err, frame_err, busy
  );

  // Receiver side.
  modport slave (
    input  tick, rx,
    output data, data_valid, parity_err, frame_err, busy
  );

endinterface

// File: rtl/parity_frame_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; reset loads the idle level into both.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/parity_frame_rx.sv
// Oversampled serial receiver: start, DATA_W bits LSB first, parity, stop.
// Reports the word with parity and stop-bit status on a one-clk data_valid.
module parity_frame_rx
  import parity_frame_rx_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned OVS        = OVS_DEF,
  parameter int unsigned PARITY_ODD = 0
) (
  input logic                clk,
  input logic                rst,
  parity_frame_rx_if.slave   bus
);

  localparam int unsigned CNT_W = ($clog2(OVS) > 0) ? $clog2(OVS) : 1;
  localparam int unsigned BIT_W = ($clog2(DATA_W) > 0) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVS / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
  localparam logic             PAR_INIT  = (PARITY_ODD != 0);

  logic rx_s;

  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      data_q  <= '0;
      dv_q    <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state and datapath updates; counters only move on tick.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    data_d  = data_q;
    dv_d    = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    unique case (state_q)
      IDLE: begin
        if (bus.tick && !rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (bus.tick) begin
          if (cnt_q == HALF_LAST) begin
            cnt_d = '0;
            if (!rx_s) begin
              state_d = DATA;
              bit_d   = '0;
              par_d   = PAR_INIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      DATA: begin
        if (bus.tick) begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            shift_d = {rx_s, shift_q[DATA_W-1:1]};
            par_d   = par_q ^ rx_s;
            if (bit_q == BIT_LAST) begin
              state_d = PARITY;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      PARITY: begin
        if (bus.tick) begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            par_d   = par_q ^ rx_s;
            state_d = STOP;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      STOP: begin
        if (bus.tick) begin
          if (cnt_q == FULL_LAST) begin
            cnt_d   = '0;
            data_d  = shift_q;
            dv_d    = 1'b1;
            perr_d  = par_q;
            ferr_d  = !rx_s;
            state_d = rx_s ? IDLE : BREAK;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.data       = data_q;
  assign bus.data_valid = dv_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule
